// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART core: parity encodings,
// TX/RX state enums and data-width helpers.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;
   localparam logic [1:0] PAR_RSVD = 2'd3;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK_WAIT
   } rx_state_e;

   function automatic logic [3:0] bit_count(input logic [1:0] data_bits);
      return 4'd5 + {2'b00, data_bits};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] data_bits);
      return 8'hFF >> (4'd8 - bit_count(data_bits));
   endfunction

   // The reserved encoding behaves as "no parity".
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: counts 0..max(divisor,1)-1 and pulses tick on
// the last count. restart zeroes the counter so a frame starts on a clean phase.
module uart_tick_gen #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 restart,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q;
   logic [DIV_WIDTH-1:0] cnt_d;
   logic [DIV_WIDTH-1:0] last_cnt;

   always_comb begin
      last_cnt = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
      tick     = (cnt_q >= last_cnt);
      cnt_d    = cnt_q + DIV_WIDTH'(1);
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_core.sv
// Runtime-configurable UART transmitter/receiver: programmable divisor,
// 5-8 data bits, optional parity, 1/2 stop bits, 3-sample majority receive.
module uart_core
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH  = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic [1:0]           data_bits,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   input  logic [7:0]           tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_break
);

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
   localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
   localparam logic [OSW-1:0] OS_S2   = OSW'(OVERSAMPLE / 2 + 1);

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [DIV_WIDTH-1:0] tx_div_q, tx_div_d;
   logic [3:0]           tx_nbits_q, tx_nbits_d;
   logic [3:0]           tx_bit_q, tx_bit_d;
   logic [7:0]           tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_par_en_q, tx_par_en_d;
   logic                 tx_two_stop_q, tx_two_stop_d;
   logic [OSW-1:0]       tx_os_q, tx_os_d;
   logic                 tx_q, tx_d;
   logic                 tx_tick, tx_fire, tx_bit_end;

   uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tx_tick (
      .clk     (clk),
      .nrst    (nrst),
      .restart (tx_fire),
      .divisor (tx_div_q),
      .tick    (tx_tick)
   );

   always_comb begin
      tx_state_d    = tx_state_q;
      tx_div_d      = tx_div_q;
      tx_nbits_d    = tx_nbits_q;
      tx_bit_d      = tx_bit_q;
      tx_shift_d    = tx_shift_q;
      tx_par_d      = tx_par_q;
      tx_par_en_d   = tx_par_en_q;
      tx_two_stop_d = tx_two_stop_q;
      tx_os_d       = tx_os_q;
      tx_fire       = tx_valid && (tx_state_q == TX_IDLE);
      tx_bit_end    = tx_tick && (tx_os_q == OS_LAST);
      if (tx_tick) begin
         tx_os_d = (tx_os_q == OS_LAST) ? '0 : tx_os_q + OSW'(1);
      end
      unique case (tx_state_q)
         TX_IDLE: begin
            if (tx_fire) begin
               tx_state_d    = TX_START;
               tx_div_d      = divisor;
               tx_nbits_d    = bit_count(data_bits);
               tx_bit_d      = 4'd0;
               tx_shift_d    = tx_data;
               tx_par_d      = (^(tx_data & data_mask(data_bits))) ^ (parity_mode == PAR_ODD);
               tx_par_en_d   = parity_enabled(parity_mode);
               tx_two_stop_d = two_stop;
               tx_os_d       = '0;
            end
         end
         TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_shift_d = tx_shift_q >> 1;
               tx_bit_d   = tx_bit_q + 4'd1;
               if (tx_bit_q == tx_nbits_q - 4'd1) begin
                  tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
               end
            end
         end
         TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP1;
         TX_STOP1:  if (tx_bit_end) tx_state_d = tx_two_stop_q ? TX_STOP2 : TX_IDLE;
         TX_STOP2:  if (tx_bit_end) tx_state_d = TX_IDLE;
         default:   tx_state_d = TX_IDLE;
      endcase
      // Line level is registered from the next state so it changes with the state.
      unique case (tx_state_d)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = tx_shift_d[0];
         TX_PARITY: tx_d = tx_par_q;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         tx_state_q    <= TX_IDLE;
         tx_div_q      <= '0;
         tx_nbits_q    <= 4'd8;
         tx_bit_q      <= 4'd0;
         tx_shift_q    <= 8'd0;
         tx_par_q      <= 1'b0;
         tx_par_en_q   <= 1'b0;
         tx_two_stop_q <= 1'b0;
         tx_os_q       <= '0;
         tx_q          <= 1'b1;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_div_q      <= tx_div_d;
         tx_nbits_q    <= tx_nbits_d;
         tx_bit_q      <= tx_bit_d;
         tx_shift_q    <= tx_shift_d;
         tx_par_q      <= tx_par_d;
         tx_par_en_q   <= tx_par_en_d;
         tx_two_stop_q <= tx_two_stop_d;
         tx_os_q       <= tx_os_d;
         tx_q          <= tx_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = (tx_state_q == TX_IDLE);

   // ---------------- receiver ----------------
   rx_state_e            rx_state_q, rx_state_d;
   logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
   logic [DIV_WIDTH-1:0] rx_div_q, rx_div_d;
   logic [3:0]           rx_nbits_q, rx_nbits_d;
   logic [3:0]           rx_bit_q, rx_bit_d;
   logic                 rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d;
   logic [OSW-1:0]       rx_os_q, rx_os_d;
   logic [1:0]           rx_votes_q, rx_votes_d;
   logic [7:0]           rx_shift_q, rx_shift_d;
   logic                 rx_par_bit_q, rx_par_bit_d, rx_any_one_q, rx_any_one_d;
   logic [7:0]           rx_data_q, rx_data_d, rx_word;
   logic                 rx_valid_q, rx_valid_d;
   logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_brk_q, rx_brk_d;
   logic                 rx_tick, rx_restart, rx_vote_now, rx_vote, rx_bit_end;

   uart_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rx_tick (
      .clk     (clk),
      .nrst    (nrst),
      .restart (rx_restart),
      .divisor (rx_div_q),
      .tick    (rx_tick)
   );

   always_comb begin
      rx_meta_d    = rx;
      rx_sync_d    = rx_meta_q;
      rx_prev_d    = rx_sync_q;
      rx_state_d   = rx_state_q;
      rx_div_d     = rx_div_q;
      rx_nbits_d   = rx_nbits_q;
      rx_bit_d     = rx_bit_q;
      rx_par_en_d  = rx_par_en_q;
      rx_odd_d     = rx_odd_q;
      rx_os_d      = rx_os_q;
      rx_votes_d   = rx_votes_q;
      rx_shift_d   = rx_shift_q;
      rx_par_bit_d = rx_par_bit_q;
      rx_any_one_d = rx_any_one_q;
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      rx_perr_d    = 1'b0;
      rx_ferr_d    = 1'b0;
      rx_brk_d     = 1'b0;
      rx_restart   = 1'b0;
      rx_word      = rx_shift_q >> (4'd8 - rx_nbits_q);
      rx_bit_end   = rx_tick && (rx_os_q == OS_LAST);
      rx_vote_now  = rx_tick && (rx_os_q == OS_S2);
      rx_vote      = (rx_votes_q[0] & rx_votes_q[1]) | (rx_votes_q[0] & rx_sync_q) |
                     (rx_votes_q[1] & rx_sync_q);
      if (rx_tick) begin
         rx_os_d = (rx_os_q == OS_LAST) ? '0 : rx_os_q + OSW'(1);
         if (rx_os_q == OS_S0) rx_votes_d[0] = rx_sync_q;
         if (rx_os_q == OS_S1) rx_votes_d[1] = rx_sync_q;
      end
      unique case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d   = RX_START;
               rx_restart   = 1'b1;
               rx_div_d     = divisor;
               rx_nbits_d   = bit_count(data_bits);
               rx_par_en_d  = parity_enabled(parity_mode);
               rx_odd_d     = (parity_mode == PAR_ODD);
               rx_os_d      = '0;
               rx_bit_d     = 4'd0;
               rx_shift_d   = 8'd0;
               rx_any_one_d = 1'b0;
            end
         end
         RX_START: begin
            if (rx_bit_end) rx_state_d = RX_DATA;
            if (rx_vote_now && rx_vote) rx_state_d = RX_IDLE;
         end
         RX_DATA: begin
            if (rx_vote_now) begin
               rx_shift_d   = {rx_vote, rx_shift_q[7:1]};
               rx_any_one_d = rx_any_one_q | rx_vote;
            end
            if (rx_bit_end) begin
               rx_bit_d = rx_bit_q + 4'd1;
               if (rx_bit_q == rx_nbits_q - 4'd1) begin
                  rx_state_d = rx_par_en_q ? RX_PARITY : RX_STOP;
               end
            end
         end
         RX_PARITY: begin
            if (rx_vote_now) begin
               rx_par_bit_d = rx_vote;
               rx_any_one_d = rx_any_one_q | rx_vote;
            end
            if (rx_bit_end) rx_state_d = RX_STOP;
         end
         RX_STOP: begin
            // Finishing at mid-stop lets the next start edge be caught early.
            if (rx_vote_now) begin
               rx_valid_d = 1'b1;
               rx_data_d  = rx_word;
               rx_perr_d  = rx_par_en_q && (rx_par_bit_q != ((^rx_word) ^ rx_odd_q));
               rx_ferr_d  = !rx_vote;
               rx_brk_d   = !rx_vote && !rx_any_one_q;
               rx_state_d = (!rx_vote && !rx_any_one_q) ? RX_BREAK_WAIT : RX_IDLE;
            end
         end
         RX_BREAK_WAIT: if (rx_sync_q) rx_state_d = RX_IDLE;
         default:       rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_div_q     <= '0;
         rx_nbits_q   <= 4'd8;
         rx_bit_q     <= 4'd0;
         rx_par_en_q  <= 1'b0;
         rx_odd_q     <= 1'b0;
         rx_os_q      <= '0;
         rx_votes_q   <= 2'b00;
         rx_shift_q   <= 8'd0;
         rx_par_bit_q <= 1'b0;
         rx_any_one_q <= 1'b0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_perr_q    <= 1'b0;
         rx_ferr_q    <= 1'b0;
         rx_brk_q     <= 1'b0;
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_prev_q    <= rx_prev_d;
         rx_state_q   <= rx_state_d;
         rx_div_q     <= rx_div_d;
         rx_nbits_q   <= rx_nbits_d;
         rx_bit_q     <= rx_bit_d;
         rx_par_en_q  <= rx_par_en_d;
         rx_odd_q     <= rx_odd_d;
         rx_os_q      <= rx_os_d;
         rx_votes_q   <= rx_votes_d;
         rx_shift_q   <= rx_shift_d;
         rx_par_bit_q <= rx_par_bit_d;
         rx_any_one_q <= rx_any_one_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         rx_perr_q    <= rx_perr_d;
         rx_ferr_q    <= rx_ferr_d;
         rx_brk_q     <= rx_brk_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_q;
   assign rx_break      = rx_brk_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: TX framing, loopback, parity/break/glitch
// handling, reset and configuration changes during frames.
module tb_uart_core;

   logic        clk = 1'b0;
   logic        nrst;
   logic [15:0] divisor;
   logic [1:0]  data_bits, parity_mode;
   logic        two_stop;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx;
   logic        rx, rx_drv, loopback;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_parity_err, rx_frame_err, rx_break;

   int n_checks = 0;
   int n_fail   = 0;
   int rx_cnt   = 0;
   logic [10:0] last_word = '0;
   logic [10:0] rx_q[$];

   always #5 clk = ~clk;
   assign rx = loopback ? tx : rx_drv;

   uart_core #(.DIV_WIDTH(16), .OVERSAMPLE(16)) dut (
      .clk(clk), .nrst(nrst), .divisor(divisor), .data_bits(data_bits),
      .parity_mode(parity_mode), .two_stop(two_stop), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .rx(rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
      .rx_frame_err(rx_frame_err), .rx_break(rx_break)
   );

   // Receive monitor: word = {parity_err, frame_err, break, data}
   always @(negedge clk) begin
      if (rx_valid) begin
         rx_cnt++;
         last_word = {rx_parity_err, rx_frame_err, rx_break, rx_data};
         rx_q.push_back(last_word);
         $display("rx frame %0d: data=0x%02h perr=%0b ferr=%0b brk=%0b",
                  rx_cnt, rx_data, rx_parity_err, rx_frame_err, rx_break);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Handshake at the next posedge; returns at the negedge of cycle N+1.
   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      chk("hs_ready", tx_ready, 1);
      @(negedge clk);
      tx_valid = 1'b0;
      $display("tx send 0x%02h", d);
   endtask

   task automatic wait_ready(input int start, output int c);
      c = start;
      while (!tx_ready && c < start + 2000) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic drive_frame(input logic [15:0] bits, input int n, input int bitcyc);
      for (int i = 0; i < n; i++) begin
         rx_drv = bits[i];
         repeat (bitcyc) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   initial begin
      int c;
      int cnt0;
      logic [9:0] frame10;
      logic [7:0] b2b [4];
      b2b = '{8'h41, 8'h7F, 8'h00, 8'h2A};

      nrst = 1'b0; divisor = 16'd2; data_bits = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; rx_drv = 1'b1; loopback = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_tx_ready", tx_ready, 1);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_flags", {rx_parity_err, rx_frame_err, rx_break}, 0);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1 TX of 0x55, divisor 2 -> 32 cycles per bit
      frame10 = {1'b1, 8'h55, 1'b0};
      send(8'h55);
      chk("tx_start_low", tx, 0);
      chk("tx_busy", tx_ready, 0);
      repeat (31) @(negedge clk);
      chk("tx_start_end", tx, 0);
      @(negedge clk);
      chk("tx_bit0_begin", tx, 1);
      repeat (15) @(negedge clk);
      for (int k = 1; k < 10; k++) begin
         chk($sformatf("tx_bit%0d", k), tx, frame10[k]);
         if (k < 9) repeat (32) @(negedge clk);
      end
      repeat (16) @(negedge clk);
      chk("tx_ready_n320", tx_ready, 0);
      @(negedge clk);
      chk("tx_ready_n321", tx_ready, 1);
      chk("tx_idle_high", tx, 1);

      // 7E2 loopback of 0x41: parity bit 0
      loopback = 1'b1; data_bits = 2'd2; parity_mode = 2'd1; two_stop = 1'b1;
      cnt0 = rx_cnt;
      send(8'h41);
      repeat (271) @(negedge clk);
      chk("7e2_parity_bit", tx, 0);
      wait_ready(272, c);
      chk("7e2_frame_len", c, 353);
      repeat (8) @(negedge clk);
      chk("7e2_rx_count", rx_cnt - cnt0, 1);
      chk("7e2_rx_word", last_word, 11'h041);

      // Back-to-back 7E2, no idle gap
      rx_q.delete();
      for (int i = 0; i < 4; i++) begin
         tx_data  = b2b[i];
         tx_valid = 1'b1;
         c = 0;
         while (!tx_ready && c < 1000) begin
            @(negedge clk);
            c++;
         end
         if (i > 0) chk("b2b_len", c, 352);
         @(negedge clk);
         chk("b2b_start", tx, 0);
      end
      tx_valid = 1'b0;
      wait_ready(1, c);
      repeat (16) @(negedge clk);
      chk("b2b_count", rx_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_word%0d", i), (rx_q.size() > i) ? rx_q[i] : 11'h7FF, {3'b000, b2b[i]});
      end
      loopback = 1'b0;

      // 8O1 frame for 0xA5 with wrong parity bit (0 instead of 1)
      data_bits = 2'd3; parity_mode = 2'd2; two_stop = 1'b0;
      repeat (40) @(negedge clk);
      cnt0 = rx_cnt;
      drive_frame({5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 32);
      repeat (32) @(negedge clk);
      chk("perr_count", rx_cnt - cnt0, 1);
      chk("perr_word", last_word, 11'h4A5);

      // Break: 20 bit times low
      cnt0 = rx_cnt;
      rx_drv = 1'b0;
      repeat (640) @(negedge clk);
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
      chk("break_count", rx_cnt - cnt0, 1);
      chk("break_word", last_word, 11'h700);
      cnt0 = rx_cnt;
      drive_frame({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 11, 32);
      repeat (32) @(negedge clk);
      chk("post_break_count", rx_cnt - cnt0, 1);
      chk("post_break_word", last_word, 11'h03C);

      // Glitch rejection: 4-cycle low pulse
      cnt0 = rx_cnt;
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
      chk("glitch_count", rx_cnt - cnt0, 0);
      drive_frame({5'b0, 1'b1, 1'b1, 8'h96, 1'b0}, 11, 32);
      repeat (32) @(negedge clk);
      chk("post_glitch_count", rx_cnt - cnt0, 1);
      chk("post_glitch_word", last_word, 11'h096);

      // Reset mid-TX frame
      send(8'hA5);
      repeat (100) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      chk("rst_mid_tx", tx, 1);
      chk("rst_mid_tx_ready", tx_ready, 1);
      nrst = 1'b1;
      @(negedge clk);
      chk("rst_mid_tx_idle", tx, 1);

      // Reset mid-RX frame
      cnt0 = rx_cnt;
      drive_frame({5'b0, 1'b1, 1'b1, 8'h3C, 1'b0}, 4, 32);
      nrst = 1'b0;
      @(negedge clk);
      chk("rst_mid_rx_valid", rx_valid, 0);
      nrst = 1'b1;
      repeat (400) @(negedge clk);
      chk("rst_mid_rx_count", rx_cnt - cnt0, 0);

      // Divisor change mid-frame keeps old timing (8N1 loopback)
      loopback = 1'b1; parity_mode = 2'd0;
      cnt0 = rx_cnt;
      send(8'h55);
      repeat (49) @(negedge clk);
      divisor = 16'd4;
      wait_ready(50, c);
      chk("div_change_len", c, 321);
      repeat (16) @(negedge clk);
      chk("div_change_rx_count", rx_cnt - cnt0, 1);
      chk("div_change_rx_word", last_word, 11'h055);
      divisor = 16'd2;
      loopback = 1'b0;

      // Divisor 0 behaves as 1: 16 cycles per bit
      divisor = 16'd0;
      send(8'hFF);
      chk("div0_start", tx, 0);
      repeat (15) @(negedge clk);
      chk("div0_start_end", tx, 0);
      @(negedge clk);
      chk("div0_bit0", tx, 1);
      wait_ready(17, c);
      chk("div0_frame_len", c, 161);
      divisor = 16'd2;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
